// File: rtl/im_loader.sv
// Byte-stream loader for the big-endian IM: 1 clk accept->write latency, 1 byte/clk peak.
// Valid/ready input, ready only while loading; hold gates fetch until the last byte commits.
module im_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             we,
    output logic [31:0]      waddr,
    output logic [7:0]       wdata,
    output logic             hold,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [32:0]      MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [CNT_W+1:0] REM_ONE   = (CNT_W+2)'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [31:0]      addr;
    logic [CNT_W+1:0] remaining;
    logic [32:0]      end_addr;
    logic             bad_req;
    logic             accept;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;

    // One bit wider than the address so a base near 4 GiB cannot wrap past the check.
    assign end_addr = {1'b0, base_addr} + {{(31-CNT_W){1'b0}}, word_count, 2'b00};
    assign bad_req  = (base_addr[1:0] != 2'b00) || (end_addr > MEM_LIMIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_req)
                        state_nxt = ERR;
                    else if (word_count == '0)
                        state_nxt = FIN;
                    else
                        state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (accept && (remaining == REM_ONE))
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start && !bad_req && (word_count != '0)) begin
                addr      <= base_addr;
                remaining <= {word_count, 2'b00};
            end else if (accept) begin
                addr      <= addr + 32'd1;
                remaining <= remaining - REM_ONE;
            end
        end
    end

    // Outputs are registered off the next state so hold/done line up with the FIN write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            hold  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            we   <= accept;
            hold <= (state_nxt == LOAD) || (state_nxt == FIN);
            done <= (state_nxt == FIN) || (state_nxt == ERR);
            err  <= (state_nxt == ERR);
            if (accept) begin
                waddr <= addr;
                wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: a byte-image and timing model predicts every write and pulse.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [8:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [7:0]  wdata;
    logic        hold;
    logic        done;
    logic        err;

    im_loader #(.MEM_BYTES(1024), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .hold(hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    int          obs_cyc[$];
    int          done_cnt, err_cnt, done_cyc, hold_cnt, hold_first, ready_cnt;
    int          oob_cnt = 0;
    logic [7:0]  mem     [0:1023];
    logic [7:0]  exp_mem [0:1023];
    logic [7:0]  pre_bytes[$];

    int n_chk  = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
            obs_cyc.push_back(cyc);
            if (waddr < 32'd1024) mem[waddr[9:0]] = wdata;
            else oob_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (err === 1'b1) err_cnt++;
        end
        if (hold === 1'b1) begin
            if (hold_cnt == 0) hold_first = cyc;
            hold_cnt++;
        end
        if (in_ready === 1'b1) ready_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        done_cyc   = -1;
        hold_cnt   = 0;
        hold_first = -1;
        ready_cnt  = 0;
    endtask

    task automatic run_load(input logic [31:0] base, input int cnt, input int vmode,
                            input bit inj, input string name);
        logic [7:0] bytes[$];
        int  n, idx, guard, start_c, last_acc, limit;
        bit  rej, acc, tog;
        rej = (base[1:0] != 2'b00) || ((longint'(base) + 4 * longint'(cnt)) > 1024);
        n   = rej ? 0 : 4 * cnt;
        for (int i = 0; i < n; i++)
            bytes.push_back((i < pre_bytes.size()) ? pre_bytes[i] : 8'($urandom));
        pre_bytes.delete();

        @(posedge clk); #1;
        clear_mon();
        start      = 1'b1;
        base_addr  = base;
        word_count = 9'(cnt);
        in_valid   = 1'b1;
        in_data    = 8'($urandom);
        start_c    = cyc;
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0; guard = 0; tog = 1'b1; last_acc = start_c;
        limit = 20 * n + 100;
        while (idx < n && guard < limit) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = ($urandom % 3) != 0;
            endcase
            in_data = bytes[idx];
            if (inj && idx == 2) begin
                start      = 1'b1;
                base_addr  = base ^ 32'h40;
                word_count = 9'd1;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && (in_ready === 1'b1);
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                idx++;
                last_acc = cyc;
            end
        end
        start = 1'b0;
        check($sformatf("%s.bytes_accepted", name), idx, n);

        // Keep offering data: a loader that overruns its count would write extra bytes.
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        guard = 0;
        while (done_cnt == 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;

        check($sformatf("%s.num_writes", name), obs_addr.size(), n);
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            check($sformatf("%s.waddr[%0d]", name, i), obs_addr[i], base + 32'(i));
            check($sformatf("%s.wdata[%0d]", name, i), obs_data[i], bytes[i]);
        end
        for (int i = 0; i < n; i++) exp_mem[base[9:0] + 10'(i)] = bytes[i];
        check($sformatf("%s.done_pulses", name), done_cnt, 1);
        check($sformatf("%s.err_pulses", name), err_cnt, rej ? 1 : 0);
        if (n > 0) begin
            if (obs_cyc.size() == n)
                check($sformatf("%s.last_we_cycle", name), obs_cyc[n-1], last_acc);
            check($sformatf("%s.done_cycle", name), done_cyc, last_acc);
            check($sformatf("%s.hold_first", name), hold_first, start_c + 1);
            check($sformatf("%s.hold_cycles", name), hold_cnt, last_acc - start_c);
            check($sformatf("%s.ready_cycles", name), ready_cnt, last_acc - start_c - 1);
        end else begin
            check($sformatf("%s.done_cycle", name), done_cyc, start_c + 1);
            check($sformatf("%s.hold_cycles", name), hold_cnt, (!rej && cnt == 0) ? 1 : 0);
            check($sformatf("%s.ready_cycles", name), ready_cnt, 0);
        end
    endtask

    initial begin
        int nbad;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        base_addr = '0; word_count = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        clear_mon();

        repeat (2) @(posedge clk);
        #1;
        check("reset.we", we, 0);
        check("reset.hold", hold, 0);
        check("reset.done", done, 0);
        check("reset.err", err, 0);
        check("reset.in_ready", in_ready, 0);
        check("reset.waddr", waddr, 0);
        check("reset.wdata", wdata, 0);
        rst = 1'b0;

        pre_bytes = '{8'h8C, 8'h01, 8'h00, 8'h04};
        run_load(32'd0, 1, 0, 1'b0, "t1_basic");
        run_load(32'd8, 2, 1, 1'b0, "t2_toggle");
        run_load(32'd16, 0, 0, 1'b0, "t3_zero");
        run_load(32'd1020, 2, 0, 1'b0, "t4_range");
        run_load(32'd2, 1, 0, 1'b0, "t4_misalign");
        run_load(32'hFFFF_FFFC, 1, 0, 1'b0, "t4_wrap");
        run_load(32'd1016, 2, 2, 1'b0, "top_edge");

        // Reset in the middle of a cycle after two of four bytes.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'd0; word_count = 9'd1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk); #1;
        in_data = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t5.we_before_rst", we, 1);
        #2 rst = 1'b1;
        #1;
        check("t5.we", we, 0);
        check("t5.hold", hold, 0);
        check("t5.in_ready", in_ready, 0);
        check("t5.done", done, 0);
        check("t5.waddr", waddr, 0);
        check("t5.wdata", wdata, 0);
        #1 rst = 1'b0;
        exp_mem[0] = 8'hA5;
        exp_mem[1] = 8'h5A;
        @(posedge clk); #1;
        check("t5.idle_ready", in_ready, 0);
        check("t5.idle_hold", hold, 0);
        run_load(32'd0, 1, 0, 1'b0, "t5_restart");

        run_load(32'd64, 3, 2, 1'b1, "t6_restart_ignored");
        run_load(32'd0, 256, 2, 1'b0, "full_mem");

        for (int t = 0; t < 30; t++) begin
            int          k, c;
            logic [31:0] b;
            k = int'($urandom % 10);
            if (k == 0) begin
                c = int'($urandom_range(1, 4));
                b = 32'(4 * $urandom_range(0, 200) + $urandom_range(1, 3));
            end else if (k == 1) begin
                c = int'($urandom_range(2, 20));
                b = 32'(4 * $urandom_range(257 - c, 255));
            end else begin
                c = int'($urandom_range(0, 6));
                b = 32'(4 * $urandom_range(0, (1024 - 4 * c) / 4));
            end
            run_load(b, c, int'($urandom % 3), ($urandom % 4) == 0, $sformatf("rnd%0d", t));
        end

        nbad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== exp_mem[i]) nbad++;
        check("mem_image_mismatches", nbad, 0);
        check("out_of_range_writes", oob_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
